// File: rtl/toy_dmem_arb.sv
// Two-port round-robin arbiter for the shared data-memory bus, with stall hold,
// an AMO lock, and a source-ID FIFO that routes in-order read acks back to their requester.
module toy_dmem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p0_req_vld,
  output logic                    p0_req_rdy,
  input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
  input  logic [DATA_WIDTH-1:0]   p0_req_data,
  input  logic [DATA_WIDTH/8-1:0] p0_req_strb,
  input  logic                    p0_req_opcode,
  input  logic                    p0_req_lock,
  output logic                    p0_ack_vld,
  input  logic                    p0_ack_rdy,
  output logic [DATA_WIDTH-1:0]   p0_ack_data,
  input  logic                    p1_req_vld,
  output logic                    p1_req_rdy,
  input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
  input  logic [DATA_WIDTH-1:0]   p1_req_data,
  input  logic [DATA_WIDTH/8-1:0] p1_req_strb,
  input  logic                    p1_req_opcode,
  input  logic                    p1_req_lock,
  output logic                    p1_ack_vld,
  input  logic                    p1_ack_rdy,
  output logic [DATA_WIDTH-1:0]   p1_ack_data,
  output logic                    mem_req_vld,
  input  logic                    mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_data,
  output logic [DATA_WIDTH/8-1:0] mem_req_strb,
  output logic                    mem_req_opcode,
  input  logic                    mem_ack_vld,
  output logic                    mem_ack_rdy,
  input  logic [DATA_WIDTH-1:0]   mem_ack_data,
  output logic                    err_unexp_ack
);

  localparam logic TOY_BUS_READ  = 1'b0;
  localparam logic TOY_BUS_WRITE = 1'b1;
  localparam int   PTR_W         = $clog2(OUT_DEPTH);
  localparam int   CNT_W         = PTR_W + 1;

  logic                 rr_ptr_q, rr_ptr_d;
  logic                 hold_q, hold_d;
  logic                 hold_id_q, hold_id_d;
  logic                 lock_valid_q, lock_valid_d;
  logic                 lock_owner_q, lock_owner_d;
  logic [OUT_DEPTH-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;

  logic       fifo_full, fifo_empty, head_id;
  logic [1:0] elig;
  logic       gnt_vld, gnt_id, accept, push, pop, gnt_lock;

  assign fifo_full  = (count_q == CNT_W'(OUT_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_id    = fifo_q[rd_ptr_q];

  // A full FIFO blocks reads even when an ack pops in the same cycle.
  assign elig[0] = p0_req_vld && ((p0_req_opcode == TOY_BUS_WRITE) || !fifo_full);
  assign elig[1] = p1_req_vld && ((p1_req_opcode == TOY_BUS_WRITE) || !fifo_full);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (hold_q) begin
      gnt_id  = hold_id_q;
      gnt_vld = elig[hold_id_q];
    end else if (lock_valid_q) begin
      gnt_id  = lock_owner_q;
      gnt_vld = elig[lock_owner_q];
    end else if (&elig) begin
      gnt_id  = rr_ptr_q;
      gnt_vld = 1'b1;
    end else if (elig[0]) begin
      gnt_vld = 1'b1;
    end else if (elig[1]) begin
      gnt_id  = 1'b1;
      gnt_vld = 1'b1;
    end
  end

  assign mem_req_vld    = gnt_vld;
  assign mem_req_addr   = gnt_id ? p1_req_addr   : p0_req_addr;
  assign mem_req_data   = gnt_id ? p1_req_data   : p0_req_data;
  assign mem_req_strb   = gnt_id ? p1_req_strb   : p0_req_strb;
  assign mem_req_opcode = gnt_id ? p1_req_opcode : p0_req_opcode;
  assign gnt_lock       = gnt_id ? p1_req_lock   : p0_req_lock;
  assign p0_req_rdy     = gnt_vld && !gnt_id && mem_req_rdy;
  assign p1_req_rdy     = gnt_vld &&  gnt_id && mem_req_rdy;

  assign accept = gnt_vld && mem_req_rdy;
  assign push   = accept && (mem_req_opcode == TOY_BUS_READ);

  // An ack with nothing outstanding is swallowed (rdy=1) and only flags the error.
  assign mem_ack_rdy   = fifo_empty ? 1'b1 : (head_id ? p1_ack_rdy : p0_ack_rdy);
  assign pop           = mem_ack_vld && mem_ack_rdy && !fifo_empty;
  assign p0_ack_vld    = mem_ack_vld && !fifo_empty && !head_id;
  assign p1_ack_vld    = mem_ack_vld && !fifo_empty &&  head_id;
  assign p0_ack_data   = mem_ack_data;
  assign p1_ack_data   = mem_ack_data;
  assign err_unexp_ack = err_q;

  always_comb begin
    rr_ptr_d     = accept ? ~rr_ptr_q : rr_ptr_q;
    hold_d       = gnt_vld && !mem_req_rdy;
    hold_id_d    = gnt_id;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (accept) begin
      if (!lock_valid_q && gnt_lock) begin
        lock_valid_d = 1'b1;
        lock_owner_d = gnt_id;
      end else if (lock_valid_q && (gnt_id == lock_owner_q) && !gnt_lock) begin
        lock_valid_d = 1'b0;
      end
    end
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = gnt_id;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    err_d    = err_q || (mem_ack_vld && fifo_empty);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= 1'b0;
      hold_q       <= 1'b0;
      hold_id_q    <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      // NOTE: the ID storage is reset as well; it is a few bits and keeps head_id defined.
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      hold_q       <= hold_d;
      hold_id_q    <= hold_id_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_toy_dmem_arb.sv
// Self-checking bench for toy_dmem_arb: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model and a per-requester data scoreboard.
module tb_toy_dmem_arb;

  localparam int   AW    = 32;
  localparam int   DW    = 32;
  localparam int   SW    = DW / 8;
  localparam int   DEPTH = 4;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    req_vld, req_op, req_lock, ack_rdy, req_rdy, ack_vld;
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_data [2];
  logic [SW-1:0] req_strb [2];
  logic [DW-1:0] ack_data0, ack_data1;
  logic          mem_req_vld, mem_req_rdy, mem_req_opcode;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data, mem_ack_data;
  logic [SW-1:0] mem_req_strb;
  logic          mem_ack_vld, mem_ack_rdy, err_unexp_ack;

  toy_dmem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p0_req_vld(req_vld[0]), .p0_req_rdy(req_rdy[0]), .p0_req_addr(req_addr[0]),
    .p0_req_data(req_data[0]), .p0_req_strb(req_strb[0]), .p0_req_opcode(req_op[0]),
    .p0_req_lock(req_lock[0]), .p0_ack_vld(ack_vld[0]), .p0_ack_rdy(ack_rdy[0]),
    .p0_ack_data(ack_data0),
    .p1_req_vld(req_vld[1]), .p1_req_rdy(req_rdy[1]), .p1_req_addr(req_addr[1]),
    .p1_req_data(req_data[1]), .p1_req_strb(req_strb[1]), .p1_req_opcode(req_op[1]),
    .p1_req_lock(req_lock[1]), .p1_ack_vld(ack_vld[1]), .p1_ack_rdy(ack_rdy[1]),
    .p1_ack_data(ack_data1),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_strb(mem_req_strb), .mem_req_opcode(mem_req_opcode),
    .mem_ack_vld(mem_ack_vld), .mem_ack_rdy(mem_ack_rdy), .mem_ack_data(mem_ack_data),
    .err_unexp_ack(err_unexp_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: arbitration bookkeeping plus the queue of outstanding read owners.
  int m_rr, m_hold, m_hold_id, m_lock, m_owner, m_err;
  int m_ids[$];
  logic [DW-1:0] pend[$];
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];
  int ack_mode;
  int last_acc;

  logic [1:0]    obs_rdy, obs_ack_vld;
  logic [AW-1:0] obs_addr;
  logic          obs_mem_ack_rdy, obs_err;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive(input int n, input bit v, input bit op, input bit lk, input logic [AW-1:0] a);
    req_vld[n]  = v;
    req_op[n]   = op;
    req_lock[n] = lk;
    req_addr[n] = a;
    req_data[n] = ~a;
    req_strb[n] = op ? (a[5:2] | 4'b0001) : 4'hF;
  endtask

  task automatic idle_inputs();
    req_vld = '0; req_op = '0; req_lock = '0; ack_rdy = '0;
    for (int n = 0; n < 2; n++) begin
      req_addr[n] = '0; req_data[n] = '0; req_strb[n] = '0;
    end
    mem_req_rdy = 1'b0;
    ack_mode    = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_rr = 0; m_hold = 0; m_hold_id = 0; m_lock = 0; m_owner = 0; m_err = 0;
    m_ids.delete(); pend.delete(); exp0.delete(); exp1.delete();
    last_acc = -1;
  endtask

  // One clock: drive memory ack, compare all outputs against the model, then advance the model.
  task automatic step();
    bit [1:0]      elig, exp_ack_vld;
    int            g, head;
    bit            gv, acc, pop, exp_ack_rdy;
    logic [6:0]    exp_ctl, obs_ctl;
    logic [DW-1:0] e, got;
    bit            mem_push, mem_pop;
    logic [AW-1:0] mem_addr;
    if (ack_mode == 1 && pend.size() > 0) begin
      mem_ack_vld = 1'b1; mem_ack_data = pend[0];
    end else if (ack_mode == 2) begin
      mem_ack_vld = 1'b1; mem_ack_data = '0;
    end else begin
      mem_ack_vld = 1'b0; mem_ack_data = '0;
    end
    #1;
    for (int n = 0; n < 2; n++)
      elig[n] = req_vld[n] && (req_op[n] == OP_WR || m_ids.size() < DEPTH);
    gv = 1'b0; g = 0;
    if (m_hold != 0)                begin g = m_hold_id; gv = elig[g]; end
    else if (m_lock != 0)           begin g = m_owner;   gv = elig[g]; end
    else if (elig == 2'b11)         begin g = m_rr;      gv = 1'b1;    end
    else if (elig[0])               begin g = 0;         gv = 1'b1;    end
    else if (elig[1])               begin g = 1;         gv = 1'b1;    end
    acc         = gv && mem_req_rdy;
    head        = (m_ids.size() > 0) ? m_ids[0] : -1;
    exp_ack_rdy = (head < 0) ? 1'b1 : ack_rdy[head];
    exp_ack_vld = '0;
    if (mem_ack_vld && head >= 0) exp_ack_vld[head] = 1'b1;
    pop = mem_ack_vld && exp_ack_rdy && head >= 0;

    exp_ctl = {gv, acc && g == 1, acc && g == 0, exp_ack_vld, exp_ack_rdy, m_err != 0};
    obs_ctl = {mem_req_vld, req_rdy, ack_vld, mem_ack_rdy, err_unexp_ack};
    n_cmp++;
    if (obs_ctl !== exp_ctl) begin
      n_bad++;
      $display("FAIL ctl t=%0t {vld,rdy1,rdy0,ackv1,ackv0,ackrdy,err} got=%b want=%b", $time, obs_ctl, exp_ctl);
    end
    if (gv) begin
      n_cmp++;
      if ({mem_req_addr, mem_req_data, mem_req_strb, mem_req_opcode} !==
          {req_addr[g], req_data[g], req_strb[g], req_op[g]}) begin
        n_bad++;
        $display("FAIL req_mux t=%0t port=%0d got addr=%h op=%b want addr=%h op=%b",
                 $time, g, mem_req_addr, mem_req_opcode, req_addr[g], req_op[g]);
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (exp_ack_vld[n] && ack_rdy[n]) begin
        got = (n == 1) ? ack_data1 : ack_data0;
        n_cmp++;
        if ((n == 1 ? exp1.size() : exp0.size()) == 0) begin
          n_bad++;
          $display("FAIL ack_data p%0d got=%h want=<none outstanding>", n, got);
        end else begin
          e = (n == 1) ? exp1.pop_front() : exp0.pop_front();
          if (got !== e) begin
            n_bad++;
            $display("FAIL ack_data p%0d t=%0t got=%h want=%h", n, $time, got, e);
          end
        end
      end
    end
    obs_rdy = req_rdy; obs_ack_vld = ack_vld; obs_addr = mem_req_addr;
    obs_mem_ack_rdy = mem_ack_rdy; obs_err = err_unexp_ack;
    mem_push = mem_req_vld && mem_req_rdy && mem_req_opcode == OP_RD;
    mem_addr = mem_req_addr;
    mem_pop  = ack_mode == 1 && mem_ack_vld && mem_ack_rdy;

    @(posedge clk);
    if (mem_pop)  void'(pend.pop_front());
    if (mem_push) pend.push_back(rd_val(mem_addr));
    if (mem_ack_vld && head < 0) m_err = 1;
    if (pop) void'(m_ids.pop_front());
    if (acc) begin
      if (req_op[g] == OP_RD) begin
        m_ids.push_back(g);
        if (g == 1) exp1.push_back(rd_val(req_addr[g]));
        else        exp0.push_back(rd_val(req_addr[g]));
      end
      m_rr = 1 - m_rr;
      if (m_lock == 0 && req_lock[g]) begin
        m_lock = 1; m_owner = g;
      end else if (m_lock != 0 && g == m_owner && !req_lock[g]) begin
        m_lock = 0;
      end
    end
    m_hold    = (gv && !mem_req_rdy) ? 1 : 0;
    m_hold_id = g;
    last_acc  = acc ? g : -1;
    #1;
  endtask

  task automatic drain();
    int c = 0;
    req_vld = '0; ack_mode = 1; ack_rdy = 2'b11; mem_req_rdy = 1'b1;
    while ((pend.size() > 0 || m_ids.size() > 0) && c < 50) begin
      step();
      c++;
    end
    n_cmp++;
    if (pend.size() != 0 || exp0.size() != 0 || exp1.size() != 0) begin
      n_bad++;
      $display("FAIL drain left pend=%0d exp0=%0d exp1=%0d want all 0", pend.size(), exp0.size(), exp1.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({mem_req_vld, req_rdy, ack_vld, mem_ack_rdy, err_unexp_ack} !== 7'b000_0010) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b want=0000010",
               {mem_req_vld, req_rdy, ack_vld, mem_ack_rdy, err_unexp_ack});
    end
    step();
  endtask

  task automatic test_alternation();
    int k0 = 0, k1 = 0, seq = 0;
    do_reset();
    mem_req_rdy = 1'b1; ack_rdy = 2'b11; ack_mode = 1;
    for (int c = 0; c < 40 && (k0 < 4 || k1 < 4); c++) begin
      drive(0, k0 < 4, OP_RD, 1'b0, 32'h1000 + 32'(k0 * 4));
      drive(1, k1 < 4, OP_RD, 1'b0, 32'h2000 + 32'(k1 * 4));
      step();
      n_cmp++;
      if (obs_rdy !== ((seq % 2 == 1) ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL alternation slot=%0d got rdy=%b want=%b", seq, obs_rdy, (seq % 2 == 1) ? 2'b10 : 2'b01);
      end
      seq++;
      if (last_acc == 0) k0++;
      if (last_acc == 1) k1++;
    end
    drain();
  endtask

  task automatic test_stall_hold();
    do_reset();
    drive(0, 1'b1, OP_RD, 1'b0, 32'h300);
    drive(1, 1'b1, OP_RD, 1'b0, 32'h400);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs_addr !== 32'h300 || obs_rdy !== 2'b00) begin
        n_bad++;
        $display("FAIL stall_hold cyc=%0d got addr=%h rdy=%b want addr=300 rdy=00", i, obs_addr, obs_rdy);
      end
    end
    mem_req_rdy = 1'b1;
    step();
    n_cmp++;
    if (obs_rdy !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_release got rdy=%b want=01", obs_rdy);
    end
    drive(0, 1'b1, OP_RD, 1'b0, 32'h304);
    step();
    n_cmp++;
    if (obs_rdy !== 2'b10 || obs_addr !== 32'h400) begin
      n_bad++;
      $display("FAIL stall_next got rdy=%b addr=%h want rdy=10 addr=400", obs_rdy, obs_addr);
    end
    drain();
  endtask

  task automatic test_amo_lock();
    do_reset();
    mem_req_rdy = 1'b1; ack_rdy = 2'b11; ack_mode = 1;
    drive(0, 1'b1, OP_RD, 1'b1, 32'h100);
    step();
    drive(0, 1'b0, OP_RD, 1'b0, 32'h0);
    drive(1, 1'b1, OP_RD, 1'b0, 32'h500);
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obs_rdy[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL lock_block cyc=%0d got p1_rdy=%b want=0", i, obs_rdy[1]);
      end
    end
    drive(0, 1'b1, OP_WR, 1'b0, 32'h100);
    step();
    n_cmp++;
    if (obs_rdy !== 2'b01) begin
      n_bad++;
      $display("FAIL lock_write got rdy=%b want=01", obs_rdy);
    end
    drive(0, 1'b0, OP_RD, 1'b0, 32'h0);
    step();
    n_cmp++;
    if (obs_rdy !== 2'b10) begin
      n_bad++;
      $display("FAIL lock_release got rdy=%b want=10", obs_rdy);
    end
    drain();
  endtask

  task automatic test_fifo_full();
    do_reset();
    mem_req_rdy = 1'b1; ack_rdy = 2'b11;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, OP_RD, 1'b0, 32'h600 + 32'(i * 4));
      step();
      n_cmp++;
      if (obs_rdy[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL fill read=%0d got p1_rdy=%b want=1", i, obs_rdy[1]);
      end
    end
    drive(1, 1'b1, OP_RD, 1'b0, 32'h610);
    drive(0, 1'b1, OP_WR, 1'b0, 32'h700);
    step();
    n_cmp++;
    if (obs_rdy !== 2'b01) begin
      n_bad++;
      $display("FAIL full_block got rdy=%b want=01", obs_rdy);
    end
    drive(0, 1'b0, OP_RD, 1'b0, 32'h0);
    ack_mode = 1;
    step();
    n_cmp++;
    if (obs_rdy[1] !== 1'b0 || obs_ack_vld !== 2'b10) begin
      n_bad++;
      $display("FAIL full_with_pop got p1_rdy=%b ack_vld=%b want p1_rdy=0 ack_vld=10", obs_rdy[1], obs_ack_vld);
    end
    ack_mode = 0;
    step();
    n_cmp++;
    if (obs_rdy !== 2'b10) begin
      n_bad++;
      $display("FAIL after_pop got rdy=%b want=10", obs_rdy);
    end
    drain();
  endtask

  task automatic test_ack_backpressure();
    do_reset();
    mem_req_rdy = 1'b1; ack_rdy = 2'b01;
    drive(1, 1'b1, OP_RD, 1'b0, 32'h800);
    step();
    drive(1, 1'b0, OP_RD, 1'b0, 32'h0);
    ack_mode = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs_mem_ack_rdy !== 1'b0 || obs_ack_vld !== 2'b10 || pend.size() != 1) begin
        n_bad++;
        $display("FAIL ack_stall cyc=%0d got ack_rdy=%b ack_vld=%b pend=%0d want 0 10 1",
                 i, obs_mem_ack_rdy, obs_ack_vld, pend.size());
      end
    end
    ack_rdy = 2'b11;
    step();
    n_cmp++;
    if (obs_mem_ack_rdy !== 1'b1 || pend.size() != 0) begin
      n_bad++;
      $display("FAIL ack_release got ack_rdy=%b pend=%0d want 1 0", obs_mem_ack_rdy, pend.size());
    end
    drain();
  endtask

  task automatic test_unexpected_ack();
    do_reset();
    ack_mode = 2;
    step();
    n_cmp++;
    if (obs_ack_vld !== 2'b00 || obs_mem_ack_rdy !== 1'b1 || obs_err !== 1'b0) begin
      n_bad++;
      $display("FAIL unexp_cycle got ack_vld=%b ack_rdy=%b err=%b want 00 1 0", obs_ack_vld, obs_mem_ack_rdy, obs_err);
    end
    ack_mode = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs_err !== 1'b1) begin
        n_bad++;
        $display("FAIL err_sticky cyc=%0d got=%b want=1", i, obs_err);
      end
    end
    do_reset();
    n_cmp++;
    if (err_unexp_ack !== 1'b0 || mem_ack_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL err_reset got err=%b ack_rdy=%b want 0 1", err_unexp_ack, mem_ack_rdy);
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req_vld[n] || last_acc == n)
          drive(n, $urandom_range(2, 0) != 0, $urandom_range(1, 0) == 1,
                $urandom_range(7, 0) == 0, $urandom & 32'hFFFF_FFFC);
      end
      mem_req_rdy = $urandom_range(3, 0) != 0;
      ack_rdy     = 2'($urandom_range(3, 0));
      ack_mode    = $urandom_range(1, 0);
      step();
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    mem_ack_vld = 1'b0;
    mem_ack_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_alternation();
    test_stall_hold();
    test_amo_lock();
    test_fifo_full();
    test_ack_backpressure();
    test_unexpected_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toy_dmem_arb.md
# toy_dmem_arb

Two-requester arbiter that shares the single data-memory bus between the LSU (port 0) and a secondary master such as a debug or DMA engine (port 1). It sits between the requesters and the memory. Its jobs:
- grant requests round-robin;
- keep a requester's grant stable while a request is stalled;
- hold an atomic lock so an AMO read/write pair is never split;
- route in-order read acknowledgements back to their originator, using a small source-ID FIFO.

## Interface
Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- OUT_DEPTH, 4, maximum outstanding reads; power of two, at least 2

Ports (the index n is 0 or 1; every port exists once per requester):
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- pn_req_vld  in  1  request valid
- pn_req_rdy  out  1  request accepted this cycle
- pn_req_addr  in  ADDR_WIDTH  byte address
- pn_req_data  in  DATA_WIDTH  write data
- pn_req_strb  in  DATA_WIDTH/8  byte strobes
- pn_req_opcode  in  1  TOY_BUS_WRITE or TOY_BUS_READ
- pn_req_lock  in  1  keep the grant after this transfer (AMO read phase)
- pn_ack_vld  out  1  read data valid for requester n
- pn_ack_rdy  in  1  requester n can take ack data
- pn_ack_data  out  DATA_WIDTH  read data
- mem_req_vld / mem_req_rdy  out / in  1  memory request handshake
- mem_req_addr, mem_req_data, mem_req_strb, mem_req_opcode  out  as on requester ports  muxed request fields
- mem_ack_vld / mem_ack_rdy  in / out  1  memory ack handshake
- mem_ack_data  in  DATA_WIDTH  read data
- err_unexp_ack  out  1  sticky: an ack arrived with no outstanding read

## Operation
Eligibility:
- A request is eligible when pn_req_vld is high, and either it is a write or the FIFO count is below OUT_DEPTH.
- A full FIFO blocks reads even if a pop happens in the same cycle.

Grant selection:
- If both requesters are eligible, the grant goes to rr_ptr. rr_ptr resets to 0 and toggles to the other port after every accepted transfer.
- Stall hold: if mem_req_vld is high and mem_req_rdy is low, the next cycle keeps the same grant, regardless of rr_ptr or a new request from the other port.
- Lock: when a transfer is accepted with pn_req_lock=1, lock_valid=1 and lock_owner=n.
  - While locked, only lock_owner may be granted; the other port sees req_rdy=0.
  - The lock clears on the next accepted transfer from lock_owner with lock=0.
  - Intended AMO sequence: read with lock=1, then write with lock=0.

Request path:
- mem_req_* carries the granted port's fields.
- mem_req_vld is high when a grant exists.
- pn_req_rdy = granted(n) and mem_req_rdy; all other ports see 0.

Source-ID FIFO:
- Push: the granted port ID, on every accepted read.
- Pop: on mem_ack_vld and mem_ack_rdy.
- Pointer widths are log2(OUT_DEPTH) and wrap naturally; count runs from 0 to OUT_DEPTH.

Ack routing:
- The head ID selects the destination: pn_ack_vld = mem_ack_vld and (head==n), and pn_ack_data = mem_ack_data.
- mem_ack_rdy = p[head]_ack_rdy when count>0, otherwise 1.
- An ack arriving at count==0 is dropped and sets err_unexp_ack, which stays set until rst.

Writes produce no ack.

## Timing
- Request path is combinational: a grant is visible on mem_req_* in the same cycle as pn_req_vld (zero latency).
- Ack path is combinational, zero latency.
- Registered state: rr_ptr, hold and hold_id, lock_valid and lock_owner, FIFO storage, pointers, count, err_unexp_ack.
- After reset:
  - rr_ptr=0, lock_valid=0, hold=0, count=0, err_unexp_ack=0.
  - With no inputs asserted, every output valid/rdy reads 0, except mem_ack_rdy=1.
- Same-cycle push and pop: count is unchanged and both pointers advance.
- A pop at count 1 and a push in the same cycle leave count=1, with the new ID at the head next cycle.
- Reset asserted mid-transaction clears all state at the next edge. Outstanding acks afterwards are treated as unexpected and flag err_unexp_ack; the system must drain memory before reset.
- Throughput: one accepted request per cycle, and one ack per cycle.

## Test plan
- Alternation: both ports issue 4 continuous reads, mem_req_rdy=1 → grants go p0,p1,p0,p1,… and each pn_ack_data matches its own address's data, in order.
- Stall hold: p0 granted and mem_req_rdy=0 for 3 cycles while p1 requests → mem_req_addr stays p0's for all 3 cycles; p1 is granted the cycle after p0 is accepted.
- AMO lock: p0 reads 0x100 with lock=1, ack returns, and p1 requests continuously → p1_req_rdy stays 0 until p0's write to 0x100 with lock=0 is accepted; p1 is granted the next cycle.
- FIFO full: OUT_DEPTH=4, withhold mem_ack_vld, issue 5 reads from p1 → the 5th is held at rdy=0 while a p0 write is still accepted; one ack then accepts the 5th read.
- Ack backpressure: p1_ack_rdy=0 while the head belongs to p1 → mem_ack_rdy=0 and the FIFO is not popped; raising p1_ack_rdy pops it in that cycle.
- Unexpected ack and reset: mem_ack_vld=1 with count=0 → err_unexp_ack=1 and stays set; rst for 1 cycle → all state returns to its reset value, err_unexp_ack=0.
